// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder in front of a
// byte-lane word memory. Requests are latched on accept, optionally delayed by
// WAIT_STATES cycles, then committed/read on the edge entering RESP. The
// response is held until the core consumes it.

// One byte lane of backing storage: write on clk, combinational read.
module data_mem_lane #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wbyte,
  output logic [7:0]    rbyte
);
  logic [7:0] mem [DEPTH_WORDS];

  // Storage is deliberately not reset; contents are defined only once written.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wbyte;
  end

  assign rbyte = mem[idx];
endmodule

module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int NUM_LANES = 4;
  localparam int AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS_CNT = WAIT_STATES[3:0];

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  state_t state, state_nx;
  logic [3:0] cnt;
  logic accept, enter_resp, fault;
  req_t live, lat, cur;
  logic [AW-1:0] idx;
  logic [NUM_LANES-1:0] be, lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wdata, lane_rdata;
  logic [31:0] rdata_nx;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign req_ready = (state == IDLE) && rst;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // Pack the live request fields.
  always_comb begin
    live.write = req_write;
    live.addr  = req_addr;
    live.wdata = req_wdata;
    live.size  = req_size;
    live.uns   = req_unsigned;
  end

  // With zero wait states the commit edge is the accept edge, so the live
  // fields are used; otherwise the latched copy is.
  assign cur = (state == IDLE) ? live : lat;

  // Fault: illegal size, misalignment, or word index beyond the storage.
  always_comb begin
    fault = 1'b0;
    if (cur.size == 2'b11)                        fault = 1'b1;
    if (cur.size == SZ_H && cur.addr[0])          fault = 1'b1;
    if (cur.size == SZ_W && cur.addr[1:0] != 2'b00) fault = 1'b1;
    if ({2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS)) fault = 1'b1;
  end

  assign idx = cur.addr[AW+1:2];

  // Byte enables and lane-replicated store data.
  always_comb begin
    be         = '0;
    lane_wdata = cur.wdata;
    unique case (cur.size)
      SZ_B: begin
        be         = 4'b0001 << cur.addr[1:0];
        lane_wdata = {4{cur.wdata[7:0]}};
      end
      SZ_H: begin
        be         = cur.addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cur.wdata[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = '0;
    endcase
  end

  // Writes only land on the RESP-entry edge, only for clean stores.
  assign lane_we = (enter_resp && cur.write && !fault) ? be : '0;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    data_mem_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .idx   (idx),
      .wbyte (lane_wdata[l]),
      .rbyte (lane_rdata[l])
    );
  end

  // Select the addressed byte/half and extend it; words pass through.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [1:0]  size,
                                           input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    unique case (size)
      SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  assign rdata_nx = (fault || cur.write) ? 32'b0
                  : fmt_load(lane_rdata, cur.addr[1:0], cur.size, cur.uns);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state; enter_resp marks the commit/read edge.
  always_comb begin
    state_nx   = state;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (WAIT_STATES == 0) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: if (cnt == 4'd1) begin
        state_nx   = RESP;
        enter_resp = 1'b1;
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, wait counter and held response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat       <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat <= live;
        cnt <= WS_CNT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_rdata <= rdata_nx;
        rsp_err   <= fault;
      end
    end
  end
endmodule
